serial_add_ctrl: RTL and testbench

//  Bit-serial N-bit adder controller. Accepts two WIDTH-bit operands plus carry-in via

---
 rtl/serial_add_pkg.sv | 11 +
 rtl/serial_fa_cell.sv | 26 ++
 rtl/serial_add_ctrl.sv | 112 +++++++++++
 tb/tb_serial_add_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding and counter sizing.
package serial_add_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_e;

  // Bit counter only needs to reach width-1; keep at least one bit.
  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// Registered 1-bit full adder; carry feeds back and is preloaded via ld.
module serial_fa_cell (
  input  logic clk,
  input  logic reset_n,
  input  logic ld,
  input  logic ld_val,
  input  logic en,
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum   <= 1'b0;
      carry <= 1'b0;
    end else if (ld) begin
      carry <= ld_val;
    end else if (en) begin
      sum   <= a ^ b ^ carry;
      carry <= (a & b) | (a & carry) | (b & carry);
    end
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder controller: valid/ready in, LSB-first through one FA cell, valid/ready out.
// Optional SERIAL_ADD_SUB_EN adds in_sub for A-B (b inverted, carry preloaded to 1).
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state, nxt;
  logic             accept, run_en, en_d, sub_sel;
  logic             cell_sum, cell_carry;
  logic [WIDTH-1:0] a_sh, b_sh, res_nxt;
  logic [WIDTH-2:0] res_sh;
  logic [CW-1:0]    cnt;

`ifdef SERIAL_ADD_SUB_EN
  assign sub_sel = in_sub;
`else
  assign sub_sel = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt    = state;
    accept = 1'b0;
    run_en = 1'b0;
    case (state)
      IDLE: if (in_valid) begin
        accept = 1'b1;
        nxt    = RUN;
      end
      RUN: begin
        run_en = 1'b1;
        if (cnt == CNT_LAST) nxt = FLUSH;
      end
      FLUSH: nxt = DONE;
      DONE:  if (out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  serial_fa_cell u_cell (
    .clk     (clk),
    .reset_n (reset_n),
    .ld      (accept),
    .ld_val  (sub_sel ? 1'b1 : in_cin),
    .en      (run_en),
    .a       (a_sh[0]),
    .b       (b_sh[0]),
    .sum     (cell_sum),
    .carry   (cell_carry)
  );

  // Newest sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
  assign res_nxt = {cell_sum, res_sh};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      cnt      <= '0;
      en_d     <= 1'b0;
      out_sum  <= '0;
      out_cout <= 1'b0;
    end else begin
      en_d <= run_en;
      if (accept) begin
        a_sh <= in_a;
        b_sh <= sub_sel ? ~in_b : in_b;
        cnt  <= '0;
      end else if (run_en) begin
        a_sh <= a_sh >> 1;
        b_sh <= b_sh >> 1;
        if (cnt != CNT_LAST) cnt <= cnt + 1'b1;
      end
      if (en_d) res_sh <= res_nxt[WIDTH-1:1];
      if (state == FLUSH) begin
        out_sum  <= res_nxt;
        out_cout <= cell_carry;
      end
    end
  end

  assign in_ready  = (state == IDLE) && reset_n;
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN) || (state == FLUSH);

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomized self-checking bench for serial_add_ctrl against a timestamp-based reference model.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid, in_ready, in_cin;
  logic [W-1:0] in_a, in_b, out_sum;
  logic         out_valid, out_ready, out_cout, busy;
`ifdef SERIAL_ADD_SUB_EN
  logic         in_sub;
`endif

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
`ifdef SERIAL_ADD_SUB_EN
    .in_sub    (in_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic cin, input logic sub);
    if (sub) return {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    return {1'b0, a} + {1'b0, b} + (W+1)'(cin);
  endfunction

  // Reference model: an accepted op becomes visible WIDTH+1 edges later and holds until handshake.
  logic         m_idle, m_valid, m_busy, m_cout;
  logic [W-1:0] m_sum;
  logic [W:0]   m_exp;
  int           m_t;

  always @(posedge clk or negedge reset_n) begin
    logic sub_now;
    if (!reset_n) begin
      m_idle = 1'b1; m_valid = 1'b0; m_busy = 1'b0; m_sum = '0; m_cout = 1'b0;
    end else begin
      cyc++;
      sub_now = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      sub_now = in_sub;
`endif
      if (m_valid) begin
        if (out_ready) begin m_valid = 1'b0; m_idle = 1'b1; end
      end else if (m_idle) begin
        if (in_valid) begin
          m_idle = 1'b0; m_busy = 1'b1; m_t = cyc;
          m_exp = ref_op(in_a, in_b, in_cin, sub_now);
        end
      end else if (cyc == m_t + W + 1) begin
        m_busy = 1'b0; m_valid = 1'b1;
        {m_cout, m_sum} = m_exp;
      end
    end
  end

  always @(negedge clk) begin
    chk("in_ready",  32'(in_ready),  32'(m_idle && reset_n));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("busy",      32'(busy),      32'(m_busy));
    chk("out_sum",   32'(out_sum),   32'(m_sum));
    chk("out_cout",  32'(out_cout),  32'(m_cout));
  end

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic sub, output logic [W-1:0] s, output logic co, output int lat);
    int n;
    int t;
    @(posedge clk); #2;
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #2; n++; end
    if (n >= 100) chk("ready_timeout", 0, 1);
    in_a = a; in_b = b; in_cin = cin;
`ifdef SERIAL_ADD_SUB_EN
    in_sub = sub;
`else
    if (sub) chk("sub_unsupported", 1, 0);
`endif
    in_valid = 1'b1;
    @(posedge clk); #1;
    t = cyc;
    #1 in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 60) begin @(negedge clk); n++; end
    if (n >= 60) chk("valid_timeout", 0, 1);
    lat = cyc - t;
    s = out_sum;
    co = out_cout;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] s, s1, ea, eb;
    logic [W:0]   e;
    logic         co, ci, r, prev;
    int           lat, idx, nres;
    int           rise[3];
    logic [W-1:0] A[3], B[3];

    reset_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
    in_sub = 1'b0;
`endif
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_sum", 32'(out_sum), 0);
    chk("rst_busy", 32'(busy), 0);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    #1 chk("ready_after_reset", 32'(in_ready), 1);

    // Basic addition and exact latency
    do_op(8'h5A, 8'h3C, 1'b0, 1'b0, s, co, lat);
    chk("t1_sum", 32'(s), 32'h96);
    chk("t1_cout", 32'(co), 0);
    chk("t1_latency", 32'(lat), 9);

    do_op(8'hFF, 8'h01, 1'b0, 1'b0, s, co, lat);
    chk("t2a_sum", 32'(s), 32'h00);
    chk("t2a_cout", 32'(co), 1);
    do_op(8'hFF, 8'hFF, 1'b1, 1'b0, s, co, lat);
    chk("t2b_sum", 32'(s), 32'hFF);
    chk("t2b_cout", 32'(co), 1);

    // Consumer stalls in DONE while in_valid pulses are ignored
    @(posedge clk); #2 out_ready = 1'b0;
    do_op(8'h21, 8'h43, 1'b1, 1'b0, s1, co, lat);
    chk("t3_sum", 32'(s1), 32'h65);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      in_valid = 1'($urandom_range(0, 1));
      in_a = W'($urandom); in_b = W'($urandom);
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("t3_valid_held", 32'(out_valid), 1);
    chk("t3_sum_held", 32'(out_sum), 32'(s1));
    @(posedge clk); #2 out_ready = 1'b1;
    @(posedge clk); #2;
    chk("t3_ready_after_hs", 32'(in_ready), 1);
    chk("t3_valid_dropped", 32'(out_valid), 0);

    // Reset during RUN cycle 4
    @(posedge clk); #2;
    in_a = 8'hC3; in_b = 8'h5D; in_cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #2 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("t4_busy", 32'(busy), 0);
    chk("t4_valid", 32'(out_valid), 0);
    chk("t4_sum", 32'(out_sum), 0);
    chk("t4_cout", 32'(out_cout), 0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    do_op(8'h01, 8'h02, 1'b0, 1'b0, s, co, lat);
    chk("t4_after_sum", 32'(s), 32'h03);
    chk("t4_after_cout", 32'(co), 0);

    // Back-to-back with in_valid held high
    for (int i = 0; i < 3; i++) begin A[i] = W'($urandom); B[i] = W'($urandom); end
    @(posedge clk); #2;
    idx = 0; nres = 0; in_cin = 1'b0;
    in_a = A[0]; in_b = B[0]; in_valid = 1'b1;
    prev = 1'b0;
    for (int c = 0; c < 80 && nres < 3; c++) begin
      @(negedge clk);
      r = in_ready;
      if (out_valid && !prev) begin
        rise[nres] = cyc;
        e = ref_op(A[nres], B[nres], 1'b0, 1'b0);
        chk("t5_sum", 32'(out_sum), 32'(e[W-1:0]));
        chk("t5_cout", 32'(out_cout), 32'(e[W]));
        nres++;
      end
      prev = out_valid;
      @(posedge clk); #2;
      if (r && in_valid) begin
        idx++;
        if (idx < 3) begin in_a = A[idx]; in_b = B[idx]; end
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    chk("t5_count", 32'(nres), 3);
    if (nres == 3) begin
      chk("t5_gap01", 32'(rise[1] - rise[0]), W + 3);
      chk("t5_gap12", 32'(rise[2] - rise[1]), W + 3);
    end

`ifdef SERIAL_ADD_SUB_EN
    do_op(8'h10, 8'h01, 1'b0, 1'b1, s, co, lat);
    chk("t6a_diff", 32'(s), 32'h0F);
    chk("t6a_cout", 32'(co), 1);
    do_op(8'h01, 8'h02, 1'b1, 1'b1, s, co, lat);
    chk("t6b_diff", 32'(s), 32'hFF);
    chk("t6b_cout", 32'(co), 0);
`endif

    // Random operations with random consumer stalls
    for (int k = 0; k < 20; k++) begin
      ea = W'($urandom); eb = W'($urandom); ci = 1'($urandom_range(0, 1));
      @(posedge clk); #2 out_ready = 1'($urandom_range(0, 1));
      do_op(ea, eb, ci, 1'b0, s, co, lat);
      e = ref_op(ea, eb, ci, 1'b0);
      chk("rnd_sum", 32'(s), 32'(e[W-1:0]));
      chk("rnd_cout", 32'(co), 32'(e[W]));
      chk("rnd_latency", 32'(lat), W + 1);
      if (!out_ready) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #2 out_ready = 1'b1;
      end
    end

    repeat (4) @(posedge clk);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
